// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared types and constants for the ysyx_23060240 load/store unit.
// Misalignment helpers are only referenced when LSU_MISALIGN_TRAP_EN is defined.
package ysyx_23060240_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] RD_LB  = 3'b000;
    localparam logic [2:0] RD_LH  = 3'b001;
    localparam logic [2:0] RD_LW  = 3'b010;
    localparam logic [2:0] RD_LBU = 3'b100;
    localparam logic [2:0] RD_LHU = 3'b101;

    localparam logic [1:0] WR_SB = 2'b00;
    localparam logic [1:0] WR_SH = 2'b01;
    localparam logic [1:0] WR_SW = 2'b10;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 256;

    // Undefined codes behave as full-word accesses, so they need word alignment.
    function automatic logic rd_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
        logic bad;
        case (ctrl)
            RD_LB, RD_LBU: bad = 1'b0;
            RD_LH, RD_LHU: bad = lo[0];
            default:       bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic wr_misaligned(input logic [1:0] ctrl, input logic [1:0] lo);
        logic bad;
        case (ctrl)
            WR_SB:   bad = 1'b0;
            WR_SH:   bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_align.sv
// Combinational byte-lane steering: store data/strobe replication and
// load lane extraction with sign/zero extension.
module ysyx_23060240_lsu_align
    import ysyx_23060240_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  wr_ctrl,
    input  logic [31:0] wr_data,
    input  logic [2:0]  rd_ctrl,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [3:0]  unused_pad_s,
    output logic [31:0] rd_ext
);

    logic [31:0] shifted_s;

    assign unused_pad_s = 4'b0000;

    // Store lane replication and strobe selection.
    always_comb begin
        wdata = wr_data;
        wstrb = 4'b1111;
        case (wr_ctrl)
            WR_SB: begin
                wdata = {4{wr_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            WR_SH: begin
                wdata = {2{wr_data[15:0]}};
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = wr_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    // Load extraction; shifting by the byte offset zero-fills a halfword at offset 3.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (rd_ctrl)
            RD_LB:   rd_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
            RD_LBU:  rd_ext = {24'h000000, shifted_s[7:0]};
            RD_LH:   rd_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
            RD_LHU:  rd_ext = {16'h0000, shifted_s[15:0]};
            default: rd_ext = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060240_lsu.sv
// Multi-cycle load/store unit: IDLE/REQ/WAIT/RESP FSM, registered bus request and
// result, response watchdog. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module ysyx_23060240_lsu
    import ysyx_23060240_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [2:0]        memory_rd_ctrl,
    input  logic [1:0]        memory_wr_ctrl,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       mem_rd_data,
    output logic              out_fault,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_we,
    output logic [31:0]       bus_req_wdata,
    output logic [3:0]        bus_req_wstrb,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rsp_rdata,
    input  logic              bus_rsp_err
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        rd_ctrl_q, rd_ctrl_d;
    logic              is_load_q, is_load_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_we_q, req_we_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic              out_valid_q, out_valid_d;
    logic              out_fault_q, out_fault_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [1:0]  align_lo_s;
    logic [31:0] align_wdata_s;
    logic [3:0]  align_wstrb_s;
    logic [3:0]  align_pad_s;
    logic [31:0] align_ext_s;
    logic        misalign_s;
    logic        wd_expire_s;

    // Store steering is only consumed in IDLE (live address), load extraction only in WAIT.
    assign align_lo_s = (state_q == ST_IDLE) ? mem_addr[1:0] : addr_lo_q;

    ysyx_23060240_lsu_align u_align (
        .addr_lo      (align_lo_s),
        .wr_ctrl      (memory_wr_ctrl),
        .wr_data      (mem_wr_data),
        .rd_ctrl      (rd_ctrl_q),
        .rdata        (bus_rsp_rdata),
        .wdata        (align_wdata_s),
        .wstrb        (align_wstrb_s),
        .unused_pad_s (align_pad_s),
        .rd_ext       (align_ext_s)
    );

    // Misalignment decode of the incoming op; stores take priority over loads.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (mem_wr_en) begin
            misalign_s = wr_misaligned(memory_wr_ctrl, mem_addr[1:0]);
        end else if (mem_rd_en) begin
            misalign_s = rd_misaligned(memory_rd_ctrl, mem_addr[1:0]);
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
    end

    assign wd_expire_s = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
    assign in_ready    = (state_q == ST_IDLE);

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        rd_ctrl_d   = rd_ctrl_q;
        is_load_d   = is_load_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        out_valid_d = out_valid_q;
        out_fault_d = out_fault_q;
        rd_data_d   = rd_data_q;
        wd_d        = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_lo_d = mem_addr[1:0];
                    rd_ctrl_d = memory_rd_ctrl;
                    is_load_d = mem_rd_en && !mem_wr_en;
                    if ((mem_wr_en || mem_rd_en) && !misalign_s) begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                        req_we_d    = mem_wr_en;
                        req_wdata_d = mem_wr_en ? align_wdata_s : 32'h0000_0000;
                        req_wstrb_d = mem_wr_en ? align_wstrb_s : 4'b0000;
                    end else begin
                        state_d     = ST_RESP;
                        out_valid_d = 1'b1;
                        out_fault_d = misalign_s;
                        rd_data_d   = 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_req_ready) begin
                    state_d     = ST_WAIT;
                    req_valid_d = 1'b0;
                    wd_d        = '0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus_rsp_valid) begin
                    state_d     = ST_RESP;
                    out_valid_d = 1'b1;
                    out_fault_d = bus_rsp_err;
                    rd_data_d   = is_load_q ? align_ext_s : 32'h0000_0000;
                end else if (wd_expire_s) begin
                    state_d     = ST_RESP;
                    out_valid_d = 1'b1;
                    out_fault_d = 1'b1;
                    rd_data_d   = 32'h0000_0000;
                end else begin
                    wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_lo_q   <= 2'b00;
            rd_ctrl_q   <= 3'b000;
            is_load_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= 32'h0000_0000;
            req_wstrb_q <= 4'b0000;
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
            rd_data_q   <= 32'h0000_0000;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            rd_ctrl_q   <= rd_ctrl_d;
            is_load_q   <= is_load_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            out_valid_q <= out_valid_d;
            out_fault_q <= out_fault_d;
            rd_data_q   <= rd_data_d;
            wd_q        <= wd_d;
        end
    end

    assign bus_req_valid = req_valid_q;
    assign bus_req_addr  = req_addr_q;
    assign bus_req_we    = req_we_q;
    assign bus_req_wdata = req_wdata_q;
    assign bus_req_wstrb = req_wstrb_q;
    assign out_valid     = out_valid_q;
    assign out_fault     = out_fault_q;
    assign mem_rd_data   = rd_data_q;

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Bench for ysyx_23060240_lsu: directed vector table, reset/hold sequences, and
// randomized ops checked against a behavioural model (honours LSU_MISALIGN_TRAP_EN).
module tb_ysyx_23060240_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mem_rd_en, mem_wr_en;
    logic [2:0]  memory_rd_ctrl;
    logic [1:0]  memory_wr_ctrl;
    logic [31:0] mem_addr, mem_wr_data;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] mem_rd_data;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_23060240_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .memory_rd_ctrl(memory_rd_ctrl), .memory_wr_ctrl(memory_wr_ctrl),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .mem_rd_data(mem_rd_data),
        .out_fault(out_fault), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we), .bus_req_wdata(bus_req_wdata),
        .bus_req_wstrb(bus_req_wstrb), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    typedef struct {
        logic [1:0]  kind;     // bit1 store enable, bit0 load enable
        logic [2:0]  rdc;
        logic [1:0]  wrc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          rdy;      // cycles bus_req_ready held low
        int          rsp;      // idle WAIT cycles before response
        logic        no_rsp;
        int          hold;     // cycles out_ready held low
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] kind, input logic [2:0] rdc, input logic [1:0] wrc,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err, input int rdy, input int rsp, input logic no_rsp, input int hold,
                                input logic ereq, input logic [31:0] eaddr, input logic ewe,
                                input logic [31:0] ewdata, input logic [3:0] ewstrb,
                                input logic [31:0] edata, input logic efault);
        vec_t v;
        v.kind = kind; v.rdc = rdc; v.wrc = wrc; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.rdy = rdy; v.rsp = rsp; v.no_rsp = no_rsp; v.hold = hold;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_we = ewe; v.exp_wdata = ewdata;
        v.exp_wstrb = ewstrb; v.exp_data = edata; v.exp_fault = efault;
        return v;
    endfunction

    // Reference model: derive expectations from access size, byte offset and arithmetic.
    function automatic vec_t model(input vec_t v);
        int          size, off;
        logic [31:0] val, mask, sbit;
        logic        is_st, is_ld, mis;
        is_st = v.kind[1];
        is_ld = !v.kind[1] && v.kind[0];
        off   = int'(v.addr % 4);
        if (is_st) size = (v.wrc == 2'd0) ? 1 : (v.wrc == 2'd1) ? 2 : 4;
        else       size = (v.rdc % 4 == 0) ? 1 : (v.rdc % 4 == 1) ? 2 : 4;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (is_st || is_ld) && (v.addr % size != 0);
`endif
        v.exp_req   = (is_st || is_ld) && !mis;
        v.exp_addr  = v.addr - off;
        v.exp_we    = is_st;
        v.exp_wstrb = 4'h0;
        v.exp_wdata = 32'h0;
        if (is_st) begin
            if (size == 1) begin
                v.exp_wstrb = 4'(1 << off);
                v.exp_wdata = (v.wdata & 32'hFF) * 32'h0101_0101;
            end else if (size == 2) begin
                v.exp_wstrb = (off >= 2) ? 4'b1100 : 4'b0011;
                v.exp_wdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
            end else begin
                v.exp_wstrb = 4'hF;
                v.exp_wdata = v.wdata;
            end
        end
        v.exp_data  = 32'h0;
        v.exp_fault = 1'b0;
        if (mis || (v.exp_req && v.no_rsp)) begin
            v.exp_fault = 1'b1;
        end else if (v.exp_req) begin
            v.exp_fault = v.err;
            if (is_ld) begin
                if (size == 4) begin
                    val = v.rdata;
                end else begin
                    mask = (size == 1) ? 32'hFF : 32'hFFFF;
                    sbit = (size == 1) ? 32'h80 : 32'h8000;
                    val  = (v.rdata >> (8 * off)) & mask;
                    if (v.rdc < 3'd4 && val >= sbit) val = val - (mask + 32'd1);
                end
                v.exp_data = val;
            end
        end
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int edges, waited, exp_edges;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; mem_wr_en = v.kind[1]; mem_rd_en = v.kind[0];
        memory_rd_ctrl = v.rdc; memory_wr_ctrl = v.wrc; mem_addr = v.addr; mem_wr_data = v.wdata;
        bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1; bus_rsp_rdata = $urandom;   // ignored in IDLE
        @(posedge clk); #1;
        in_valid = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        edges = 0;
        if (v.exp_req) begin
            chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            for (int i = 0; i <= v.rdy; i++) begin
                chk({tag, ".req_valid"}, {31'd0, bus_req_valid}, 32'd1);
                chk({tag, ".req_addr"}, bus_req_addr, v.exp_addr);
                chk({tag, ".req_we"}, {31'd0, bus_req_we}, {31'd0, v.exp_we});
                if (v.exp_we) begin
                    chk({tag, ".req_wdata"}, bus_req_wdata, v.exp_wdata);
                    chk({tag, ".req_wstrb"}, {28'd0, bus_req_wstrb}, {28'd0, v.exp_wstrb});
                end
                bus_req_ready = (i == v.rdy);
                @(posedge clk); #1; edges++;
            end
            bus_req_ready = 1'b0;
            chk({tag, ".req_drop"}, {31'd0, bus_req_valid}, 32'd0);
            waited = 0;
            while (!out_valid && edges < 40) begin
                if (!v.no_rsp && waited == v.rsp) begin
                    bus_rsp_valid = 1'b1; bus_rsp_rdata = v.rdata; bus_rsp_err = v.err;
                end
                @(posedge clk); #1; edges++; waited++;
                bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
            end
            exp_edges = v.rdy + 2 + (v.no_rsp ? TMO - 1 : v.rsp);
        end else begin
            chk({tag, ".no_req"}, {31'd0, bus_req_valid}, 32'd0);
            exp_edges = 0;
        end
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".latency"}, edges, exp_edges);
        for (int i = 0; i <= v.hold; i++) begin
            chk({tag, ".data"}, mem_rd_data, v.exp_data);
            chk({tag, ".fault"}, {31'd0, out_fault}, {31'd0, v.exp_fault});
            chk({tag, ".held"}, {31'd0, out_valid}, 32'd1);
            out_ready = (i == v.hold);
            bus_rsp_valid = (i != v.hold); bus_rsp_rdata = $urandom; bus_rsp_err = 1'b1;  // late: ignored
            @(posedge clk); #1;
        end
        out_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        chk({tag, ".out_done"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".out_fault"}, {31'd0, out_fault}, 32'd0);
        chk({tag, ".req_valid"}, {31'd0, bus_req_valid}, 32'd0);
        chk({tag, ".req_we"}, {31'd0, bus_req_we}, 32'd0);
        chk({tag, ".req_addr"}, bus_req_addr, 32'd0);
        chk({tag, ".req_wdata"}, bus_req_wdata, 32'd0);
        chk({tag, ".req_wstrb"}, {28'd0, bus_req_wstrb}, 32'd0);
        chk({tag, ".rd_data"}, mem_rd_data, 32'd0);
    endtask

    vec_t tbl[13];
    vec_t rv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        memory_rd_ctrl = 3'd0; memory_wr_ctrl = 2'd0; mem_addr = 32'd0; mem_wr_data = 32'd0;
        out_ready = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        bus_rsp_rdata = 32'd0;

        //            kind  rdc     wrc    addr          wdata         rdata        err  rdy rsp nr hold  req  eaddr         we   ewdata        wstrb    edata         fault
        tbl[0]  = mk(2'b01, 3'b000, 2'b00, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 0, 0, 0,   1, 32'h8000_0000, 0, 32'h0,        4'h0,   32'hFFFF_FF80, 0);
        tbl[1]  = mk(2'b10, 3'b000, 2'b01, 32'h8000_0002, 32'h0000_BEEF, 32'h0,       0, 0, 1, 0, 1,   1, 32'h8000_0000, 1, 32'hBEEF_BEEF, 4'b1100, 32'h0,        0);
        tbl[2]  = mk(2'b01, 3'b101, 2'b00, 32'h8000_0002, 32'h0,        32'h1234_F00D, 0, 5, 0, 0, 0,   1, 32'h8000_0000, 0, 32'h0,        4'h0,   32'h0000_1234, 0);
        tbl[3]  = mk(2'b00, 3'b000, 2'b00, 32'h8000_0000, 32'h0,        32'h0,         0, 0, 0, 0, 2,   0, 32'h0,        0, 32'h0,        4'h0,   32'h0,         0);
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[4]  = mk(2'b01, 3'b010, 2'b00, 32'h8000_0011, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 0, 0,   0, 32'h0,        0, 32'h0,        4'h0,   32'h0,         1);
        tbl[5]  = mk(2'b01, 3'b001, 2'b00, 32'h8000_0023, 32'h0,        32'hF012_3456, 0, 0, 0, 0, 0,   0, 32'h0,        0, 32'h0,        4'h0,   32'h0,         1);
`else
        tbl[4]  = mk(2'b01, 3'b010, 2'b00, 32'h8000_0011, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 0, 0,   1, 32'h8000_0010, 0, 32'h0,        4'h0,   32'hCAFE_F00D, 0);
        tbl[5]  = mk(2'b01, 3'b001, 2'b00, 32'h8000_0023, 32'h0,        32'hF012_3456, 0, 0, 0, 0, 0,   1, 32'h8000_0020, 0, 32'h0,        4'h0,   32'h0000_00F0, 0);
`endif
        tbl[6]  = mk(2'b10, 3'b000, 2'b00, 32'h8000_0041, 32'h1234_56AB, 32'h0,       0, 1, 0, 0, 0,   1, 32'h8000_0040, 1, 32'hABAB_ABAB, 4'b0010, 32'h0,        0);
        tbl[7]  = mk(2'b10, 3'b000, 2'b10, 32'h8000_0030, 32'h0102_0304, 32'h0,       1, 0, 2, 0, 0,   1, 32'h8000_0030, 1, 32'h0102_0304, 4'hF,   32'h0,         1);
        tbl[8]  = mk(2'b01, 3'b100, 2'b00, 32'h8000_0006, 32'h0,        32'h00C3_0000, 0, 0, 0, 0, 0,   1, 32'h8000_0004, 0, 32'h0,        4'h0,   32'h0000_00C3, 0);
        tbl[9]  = mk(2'b01, 3'b001, 2'b00, 32'h8000_0008, 32'h0,        32'h0000_8001, 0, 0, 0, 0, 0,   1, 32'h8000_0008, 0, 32'h0,        4'h0,   32'hFFFF_8001, 0);
        tbl[10] = mk(2'b11, 3'b000, 2'b10, 32'h8000_000C, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 0, 0, 0, 1, 32'h8000_000C, 1, 32'hDEAD_BEEF, 4'hF,   32'h0,         0);
        tbl[11] = mk(2'b01, 3'b010, 2'b00, 32'h8000_0020, 32'h0,        32'h7777_7777, 0, 0, 0, 1, 2,   1, 32'h8000_0020, 0, 32'h0,        4'h0,   32'h0,         1);
        tbl[12] = mk(2'b01, 3'b111, 2'b11, 32'h8000_0004, 32'h0,        32'h89AB_CDEF, 0, 0, 0, 0, 0,   1, 32'h8000_0004, 0, 32'h0,        4'h0,   32'h89AB_CDEF, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("reset");

        for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Undefined store code acts as SW.
        run_op(mk(2'b10, 3'b000, 2'b11, 32'h8000_0008, 32'h1357_9BDF, 32'h0, 0, 0, 0, 0, 0,
                  1, 32'h8000_0008, 1, 32'h1357_9BDF, 4'hF, 32'h0, 0), "sw_undef");

        // Reset while waiting for a response; the response that follows must be dropped.
        in_valid = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b0; memory_rd_ctrl = 3'b010;
        mem_addr = 32'h8000_0100;
        @(posedge clk); #1; in_valid = 1'b0; bus_req_ready = 1'b1;
        @(posedge clk); #1; bus_req_ready = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk_reset("rst_wait");
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hDEAD_0001;
        @(posedge clk); #1; bus_rsp_valid = 1'b0;
        chk("rst_wait.drop_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wait.drop_ready", {31'd0, in_ready}, 32'd1);

        // Reset while a result is held in RESP.
        in_valid = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("resp_hold.valid", {31'd0, out_valid}, 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk_reset("rst_resp");

        for (int n = 0; n < 80; n++) begin
            rv.kind = 2'($urandom_range(0, 3)); rv.rdc = 3'($urandom_range(0, 7));
            rv.wrc = 2'($urandom_range(0, 3)); rv.addr = $urandom; rv.wdata = $urandom;
            rv.rdata = $urandom; rv.err = ($urandom_range(0, 7) == 0);
            rv.rdy = $urandom_range(0, 3); rv.rsp = $urandom_range(0, TMO - 2);
            rv.no_rsp = ($urandom_range(0, 9) == 0); rv.hold = $urandom_range(0, 2);
`ifndef LSU_MISALIGN_TRAP_EN
            if (rv.kind == 2'b01 && rv.rdc % 4 == 1) rv.addr[0] = 1'b0;
            if (rv.kind == 2'b01 && rv.rdc % 4 >= 2) rv.addr[1:0] = 2'b00;
`endif
            run_op(model(rv), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
